// File: rtl/sel_coeff_bank.sv
// Coefficient bank with direct-load and saturating-update writes, a DEPTH-cycle bank clear and 1-cycle registered reads.
// Writes stall (in_ready low) for 1 cycle after an update and for DEPTH cycles during a clear; reads never stall.
module sel_coeff_bank #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [AW-1:0]           in_addr,
   input  logic signed [WIDTH-1:0] input_k,
   input  logic signed [WIDTH-1:0] update_k,
   input  logic                    update_coeff,
   input  logic                    clr,
   input  logic                    rd_en,
   input  logic [AW-1:0]           rd_addr,
   output logic                    rd_valid,
   output logic signed [WIDTH-1:0] k,
   output logic                    sat,
   output logic                    busy
);
   typedef enum logic [1:0] {IDLE, ACC, CLEAR} state_t;

   localparam logic [AW:0]             DEPTH_W = (AW+1)'(DEPTH);
   localparam logic [AW-1:0]           LAST    = AW'(DEPTH-1);
   localparam logic signed [WIDTH-1:0] K_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH-1:0] K_MIN   = {1'b1, {(WIDTH-1){1'b0}}};

   state_t                  state, state_nxt;
   logic [AW-1:0]           cnt;
   logic [AW-1:0]           acc_addr;
   logic signed [WIDTH-1:0] acc_delta;
   logic signed [WIDTH-1:0] mem [DEPTH];

   logic                    in_fire;
   logic                    wr_in_range, acc_in_range, rd_in_range;
   logic signed [WIDTH-1:0] acc_cur;
   logic [WIDTH:0]          acc_sum;
   logic                    acc_ovf;
   logic signed [WIDTH-1:0] acc_res;

   assign in_ready     = (state == IDLE) && !clr;
   assign busy         = (state != IDLE);
   assign in_fire      = in_valid && in_ready;
   assign wr_in_range  = {1'b0, in_addr}  < DEPTH_W;
   assign acc_in_range = {1'b0, acc_addr} < DEPTH_W;
   assign rd_in_range  = {1'b0, rd_addr}  < DEPTH_W;

   // One guard bit: overflow shows up as the top two sum bits disagreeing.
   assign acc_cur = acc_in_range ? mem[acc_addr] : '0;
   assign acc_sum = {acc_cur[WIDTH-1], acc_cur} + {acc_delta[WIDTH-1], acc_delta};
   assign acc_ovf = acc_sum[WIDTH] != acc_sum[WIDTH-1];
   assign acc_res = !acc_ovf ? acc_sum[WIDTH-1:0] : (acc_sum[WIDTH] ? K_MIN : K_MAX);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (clr)                          state_nxt = CLEAR;
            else if (in_fire && update_coeff) state_nxt = ACC;
         end
         ACC:     state_nxt = IDLE;
         CLEAR:   if (cnt == LAST) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Reads sample mem before this edge's write lands, giving read-before-write.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         cnt       <= '0;
         acc_addr  <= '0;
         acc_delta <= '0;
         k         <= '0;
         rd_valid  <= 1'b0;
         sat       <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) k <= rd_in_range ? mem[rd_addr] : '0;
         sat <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (in_fire) begin
                  if (update_coeff) begin
                     acc_addr  <= in_addr;
                     acc_delta <= update_k;
                  end else if (wr_in_range) begin
                     mem[in_addr] <= input_k;
                  end
               end
            end
            ACC: begin
               if (acc_in_range) begin
                  mem[acc_addr] <= acc_res;
                  sat           <= acc_ovf;
               end
            end
            CLEAR: begin
               mem[cnt] <= '0;
               cnt      <= cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_sel_coeff_bank.sv
// Randomized bench for sel_coeff_bank against a per-edge action-queue model, plus directed literal checks.
module tb_sel_coeff_bank;
   localparam int W = 16;
   localparam int D = 8;
   localparam int A = 3;

   logic                clk = 1'b0;
   logic                rst;
   logic                in_valid;
   logic                in_ready;
   logic [A-1:0]        in_addr;
   logic signed [W-1:0] input_k;
   logic signed [W-1:0] update_k;
   logic                update_coeff;
   logic                clr;
   logic                rd_en;
   logic [A-1:0]        rd_addr;
   logic                rd_valid;
   logic signed [W-1:0] k;
   logic                sat;
   logic                busy;

   int errors = 0;
   int checks = 0;

   sel_coeff_bank #(.WIDTH(W), .DEPTH(D)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_addr(in_addr), .input_k(input_k), .update_k(update_k),
      .update_coeff(update_coeff), .clr(clr), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_valid(rd_valid), .k(k), .sat(sat), .busy(busy)
   );

   always #5 clk = ~clk;

   // Model: each accepted multi-cycle request becomes a list of pending
   // per-edge writes; the bank is busy while that list is non-empty.
   typedef struct {
      bit is_clr;
      int addr;
      int delta;
   } act_t;

   act_t        q[$];
   logic [15:0] m_mem [D];
   logic [15:0] m_k;
   logic        m_rv;
   logic        m_sat;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      act_t a;
      int   s;
      if (rst) begin
         for (int i = 0; i < D; i++) m_mem[i] = 16'h0;
         q.delete();
         m_k = 16'h0; m_rv = 1'b0; m_sat = 1'b0;
         return;
      end
      m_rv = rd_en;
      if (rd_en) m_k = (int'(rd_addr) < D) ? m_mem[rd_addr] : 16'h0;
      m_sat = 1'b0;
      if (q.size() != 0) begin
         a = q.pop_front();
         if (a.is_clr) begin
            m_mem[a.addr] = 16'h0;
         end else begin
            s = int'($signed(m_mem[a.addr])) + a.delta;
            if (s > 32767)       begin s = 32767;  m_sat = 1'b1; end
            else if (s < -32768) begin s = -32768; m_sat = 1'b1; end
            m_mem[a.addr] = 16'(s);
         end
      end else if (clr) begin
         for (int i = 0; i < D; i++) q.push_back('{is_clr: 1'b1, addr: i, delta: 0});
      end else if (in_valid) begin
         if (update_coeff)
            q.push_back('{is_clr: 1'b0, addr: int'(in_addr), delta: int'(update_k)});
         else if (int'(in_addr) < D)
            m_mem[in_addr] = input_k;
      end
   endtask

   task automatic compare_all();
      check("in_ready", {15'b0, in_ready}, {15'b0, (q.size() == 0) && !clr});
      check("busy",     {15'b0, busy},     {15'b0, q.size() != 0});
      check("rd_valid", {15'b0, rd_valid}, {15'b0, m_rv});
      check("sat",      {15'b0, sat},      {15'b0, m_sat});
      check("k",        k,                 m_k);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
   endtask

   task automatic idle_in();
      rst = 1'b0; in_valid = 1'b0; in_addr = '0; input_k = '0; update_k = '0;
      update_coeff = 1'b0; clr = 1'b0; rd_en = 1'b0; rd_addr = '0;
   endtask

   task automatic load(input int addr, input logic [15:0] val);
      idle_in(); in_valid = 1'b1; in_addr = A'(addr); input_k = val; tick();
   endtask

   task automatic upd(input int addr, input logic [15:0] dlt);
      idle_in(); in_valid = 1'b1; update_coeff = 1'b1; in_addr = A'(addr); update_k = dlt; tick();
   endtask

   task automatic rd(input int addr);
      idle_in(); rd_en = 1'b1; rd_addr = A'(addr); tick();
   endtask

   function automatic logic [15:0] pick();
      logic [15:0] v;
      case ($urandom_range(0, 3))
         0:       v = 16'($urandom);
         1:       v = 16'h7000 | 16'($urandom_range(0, 16'h0FFF));
         2:       v = 16'h8000 | 16'($urandom_range(0, 16'h0FFF));
         default: v = 16'($urandom_range(0, 16'h07FF));
      endcase
      return v;
   endfunction

   initial begin
      int nbusy;
      idle_in();
      rst = 1'b1;
      tick(); tick();
      check("rst_k", k, 16'h0);
      check("rst_rd_valid", {15'b0, rd_valid}, 16'h0);
      check("rst_sat", {15'b0, sat}, 16'h0);
      check("rst_busy", {15'b0, busy}, 16'h0);
      idle_in(); tick();
      check("rst_in_ready", {15'b0, in_ready}, 16'h1);

      // direct load then read
      load(3, 16'h0400);
      rd(3);
      check("load_k", k, 16'h0400);
      check("load_rd_valid", {15'b0, rd_valid}, 16'h1);
      check("load_sat", {15'b0, sat}, 16'h0);

      // update stalls one cycle
      load(2, 16'h0400);
      upd(2, 16'hFE00);
      check("upd_busy", {15'b0, busy}, 16'h1);
      check("upd_in_ready", {15'b0, in_ready}, 16'h0);
      idle_in(); tick();
      check("upd_busy_done", {15'b0, busy}, 16'h0);
      rd(2);
      check("upd_k", k, 16'h0200);

      // positive then negative saturation
      load(1, 16'h7F00);
      upd(1, 16'h0200);
      idle_in(); tick();
      check("sat_pos_pulse", {15'b0, sat}, 16'h1);
      idle_in(); tick();
      check("sat_pos_low", {15'b0, sat}, 16'h0);
      rd(1);
      check("sat_pos_k", k, 16'h7FFF);
      load(1, 16'h8100);
      upd(1, 16'hFE00);
      idle_in(); tick();
      check("sat_neg_pulse", {15'b0, sat}, 16'h1);
      rd(1);
      check("sat_neg_k", k, 16'h8000);

      // same-address read and write returns the old value
      idle_in(); in_valid = 1'b1; in_addr = 3'd4; input_k = 16'h0123;
      rd_en = 1'b1; rd_addr = 3'd4; tick();
      check("rbw_old", k, 16'h0000);
      rd(4);
      check("rbw_new", k, 16'h0123);

      // clear colliding with a write, read ahead of the sweep
      for (int i = 0; i < D; i++) load(i, 16'(16'h1000 + i));
      idle_in(); clr = 1'b1; in_valid = 1'b1; in_addr = 3'd0; input_k = 16'h5555; tick();
      check("clr_busy", {15'b0, busy}, 16'h1);
      nbusy = 1;
      rd(5);
      check("clr_rd5_old", k, 16'h1005);
      if (busy) nbusy++;
      for (int i = 0; i < D; i++) begin
         idle_in(); tick();
         if (busy) nbusy++;
      end
      check("clr_busy_cycles", 16'(nbusy), 16'd8);
      for (int i = 0; i < D; i++) begin
         rd(i);
         check("clr_zero", k, 16'h0);
      end

      // reset in the ACC cycle discards the update
      load(6, 16'h0777);
      upd(6, 16'h0100);
      idle_in(); rst = 1'b1; tick();
      idle_in(); tick();
      check("racc_in_ready", {15'b0, in_ready}, 16'h1);
      check("racc_sat", {15'b0, sat}, 16'h0);
      check("racc_busy", {15'b0, busy}, 16'h0);
      rd(6);
      check("racc_k", k, 16'h0);

      // randomized traffic
      for (int c = 0; c < 4000; c++) begin
         rst          = ($urandom_range(0, 199) == 0);
         clr          = ($urandom_range(0, 39) == 0);
         in_valid     = 1'($urandom_range(0, 1));
         update_coeff = 1'($urandom_range(0, 1));
         in_addr      = A'($urandom_range(0, D - 1));
         input_k      = pick();
         update_k     = pick();
         rd_en        = ($urandom_range(0, 9) < 6);
         rd_addr      = A'($urandom_range(0, D - 1));
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
